// File: rtl/brick_render_pkg.sv
// Shared game constants: screen, ball, brick grid and paddle geometry, plus the colour palette.
// Imported by the renderer and by ball_control so both agree on the playfield.
package brick_render_pkg;

    localparam int unsigned GAME_H       = 640;
    localparam int unsigned GAME_V       = 480;
    localparam int unsigned GAME_BALL_W  = 16;
    localparam int unsigned GAME_BALL_H  = 10;
    localparam int unsigned GAME_BRICK_W = 32;
    localparam int unsigned GAME_BRICK_H = 20;
    localparam int unsigned GAME_BOARD_Y = 467;
    localparam int unsigned GAME_BOARD_W = 96;
    localparam int unsigned GAME_BOARD_H = 10;

    localparam int unsigned GRID_COLS = 20;
    localparam int unsigned GRID_ROWS = 24;
    localparam int unsigned CELL_BITS = 3;
    localparam int unsigned ROW_BITS  = GRID_COLS * CELL_BITS;
    localparam int unsigned MAP_BITS  = ROW_BITS * GRID_ROWS;

    typedef logic [11:0]          rgb444_t;
    typedef logic [CELL_BITS-1:0] cell_code_t;

    localparam rgb444_t COLOR_BG    = 12'h000;
    localparam rgb444_t COLOR_BALL  = 12'hFFF;
    localparam rgb444_t COLOR_BOARD = 12'h0AF;

    localparam rgb444_t PAL_1 = 12'hF00;
    localparam rgb444_t PAL_2 = 12'hF80;
    localparam rgb444_t PAL_3 = 12'hFF0;
    localparam rgb444_t PAL_4 = 12'h0F0;
    localparam rgb444_t PAL_5 = 12'h0FF;
    localparam rgb444_t PAL_6 = 12'h00F;
    localparam rgb444_t PAL_7 = 12'hF0F;

endpackage

// File: rtl/brick_palette.sv
// Combinational brick colour lookup: 3-bit cell code to RGB444.
// Code 0 (empty cell) maps to background.
module brick_palette
    import brick_render_pkg::*;
(
    input  cell_code_t code,
    output rgb444_t    color
);

    always_comb begin
        color = COLOR_BG;
        case (code)
            3'd1:    color = PAL_1;
            3'd2:    color = PAL_2;
            3'd3:    color = PAL_3;
            3'd4:    color = PAL_4;
            3'd5:    color = PAL_5;
            3'd6:    color = PAL_6;
            3'd7:    color = PAL_7;
            default: color = COLOR_BG;
        endcase
    end

endmodule

// File: rtl/brick_render.sv
// Two-stage pixel renderer for the brick game: ball, paddle, brick grid over black.
// Game objects are sampled into snapshot registers on frame_start so a frame never tears.
module brick_render
    import brick_render_pkg::*;
#(
    parameter int unsigned H       = GAME_H,
    parameter int unsigned V       = GAME_V,
    parameter int unsigned BALL_W  = GAME_BALL_W,
    parameter int unsigned BALL_H  = GAME_BALL_H,
    parameter int unsigned BRICK_W = GAME_BRICK_W,
    parameter int unsigned BRICK_H = GAME_BRICK_H,
    parameter int unsigned BOARD_Y = GAME_BOARD_Y,
    parameter int unsigned BOARD_W = GAME_BOARD_W,
    parameter int unsigned BOARD_H = GAME_BOARD_H
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          h_cnt,
    input  logic [9:0]          v_cnt,
    input  logic                valid,
    input  logic                frame_start,
    input  logic [MAP_BITS-1:0] bricks,
    input  logic [9:0]          ball_x,
    input  logic [9:0]          ball_y,
    input  logic [9:0]          board_x,
    output logic [11:0]         pixel,
    output logic                pixel_valid,
    output logic [7:0]          frame_cnt
);

    localparam int unsigned COL_W = $clog2(GRID_COLS);
    localparam int unsigned ROW_W = $clog2(GRID_ROWS);
    localparam int unsigned LX_W  = $clog2(BRICK_W);
    localparam int unsigned LY_W  = $clog2(BRICK_H);

    logic [MAP_BITS-1:0] snap_bricks;
    logic [9:0]          snap_ball_x;
    logic [9:0]          snap_ball_y;
    logic [9:0]          snap_board_x;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_bricks  <= '0;
            snap_ball_x  <= '0;
            snap_ball_y  <= '0;
            snap_board_x <= '0;
            frame_cnt    <= '0;
        end else if (frame_start) begin
            snap_bricks  <= bricks;
            snap_ball_x  <= ball_x;
            snap_ball_y  <= ball_y;
            snap_board_x <= board_x;
            frame_cnt    <= frame_cnt + 8'd1;
        end
    end

    // Stage 1: geometry. All compares are 11 bits wide so position+size never wraps.
    logic [10:0]         h11;
    logic [10:0]         v11;
    logic                in_range_c;
    logic                ball_hit_c;
    logic                board_hit_c;
    logic [COL_W-1:0]    col_c;
    logic [ROW_W-1:0]    row_c;
    logic [LX_W-1:0]     lx_c;
    logic [LY_W-1:0]     ly_c;
    logic [ROW_BITS-1:0] row_bits_c;

    assign h11 = {1'b0, h_cnt};
    assign v11 = {1'b0, v_cnt};

    assign in_range_c  = valid && (h11 < 11'(H)) && (v11 < 11'(V));
    assign ball_hit_c  = ({1'b0, snap_ball_x} <= h11) && (h11 < {1'b0, snap_ball_x} + 11'(BALL_W)) &&
                         ({1'b0, snap_ball_y} <= v11) && (v11 < {1'b0, snap_ball_y} + 11'(BALL_H));
    assign board_hit_c = ({1'b0, snap_board_x} <= h11) && (h11 < {1'b0, snap_board_x} + 11'(BOARD_W)) &&
                         (11'(BOARD_Y) <= v11) && (v11 < 11'(BOARD_Y) + 11'(BOARD_H));

    assign col_c = COL_W'(h_cnt / 10'(BRICK_W));
    assign row_c = ROW_W'(v_cnt / 10'(BRICK_H));
    assign lx_c  = LX_W'(h_cnt % 10'(BRICK_W));
    assign ly_c  = LY_W'(v_cnt % 10'(BRICK_H));

    // The row is pulled out of the snapshot here, in the same cycle as the hit flags,
    // so a pixel coinciding with frame_start still sees the old map. The explicit
    // row compare keeps off-screen coordinates from indexing past the map.
    always_comb begin
        row_bits_c = '0;
        if (in_range_c) begin
            for (int r = 0; r < int'(GRID_ROWS); r++) begin
                if (row_c == ROW_W'(r)) begin
                    row_bits_c = snap_bricks[r*ROW_BITS +: ROW_BITS];
                end
            end
        end
    end

    logic                s1_valid;
    logic                s1_in_range;
    logic                s1_ball;
    logic                s1_board;
    logic [COL_W-1:0]    s1_col;
    logic [LX_W-1:0]     s1_lx;
    logic [LY_W-1:0]     s1_ly;
    logic [ROW_BITS-1:0] s1_row_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_ball     <= 1'b0;
            s1_board    <= 1'b0;
            s1_col      <= '0;
            s1_lx       <= '0;
            s1_ly       <= '0;
            s1_row_bits <= '0;
        end else begin
            s1_valid    <= valid;
            s1_in_range <= in_range_c;
            s1_ball     <= ball_hit_c;
            s1_board    <= board_hit_c;
            s1_col      <= col_c;
            s1_lx       <= lx_c;
            s1_ly       <= ly_c;
            s1_row_bits <= row_bits_c;
        end
    end

    // Stage 2: cell code lookup and priority colour select.
    cell_code_t code_c;
    rgb444_t    brick_color;
    rgb444_t    color_c;

    always_comb begin
        code_c = '0;
        for (int c = 0; c < int'(GRID_COLS); c++) begin
            if (s1_col == COL_W'(c)) begin
                code_c = s1_row_bits[c*CELL_BITS +: CELL_BITS];
            end
        end
    end

    brick_palette u_palette (
        .code  (code_c),
        .color (brick_color)
    );

    always_comb begin
        color_c = COLOR_BG;
        if (!s1_in_range) begin
            color_c = COLOR_BG;
        end else if (s1_ball) begin
            color_c = COLOR_BALL;
        end else if (s1_board) begin
            color_c = COLOR_BOARD;
        end else if ((code_c != '0) && (s1_lx != '0) && (s1_ly != '0)) begin
            color_c = brick_color;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel       <= COLOR_BG;
            pixel_valid <= 1'b0;
        end else begin
            pixel       <= color_c;
            pixel_valid <= s1_valid;
        end
    end

endmodule

// File: tb/tb_brick_render.sv
// Directed bench for brick_render: vector table for the static renders, hand sequences
// for snapshot timing, frame counter wrap and mid-line reset.
module tb_brick_render;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          valid;
    logic          frame_start;
    logic [1439:0] bricks;
    logic [9:0]    ball_x;
    logic [9:0]    ball_y;
    logic [9:0]    board_x;
    logic [11:0]   pixel;
    logic          pixel_valid;
    logic [7:0]    frame_cnt;

    int checks = 0;
    int errors = 0;

    brick_render dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .frame_start (frame_start),
        .bricks      (bricks),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .board_x     (board_x),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic        vld;
        logic [11:0] exp_pixel;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_cell(input int c, input int r, input logic [2:0] code);
        bricks[3*c + 60*r +: 3] = code;
    endtask

    // Holds the coordinate for two edges so the output after the second edge belongs to it.
    task automatic run_px(input int h, input int v, input logic vld);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        valid = vld;
        step();
        step();
    endtask

    task automatic add(input int h, input int v, input logic vld, input logic [11:0] e, input string n);
        vec_t t;
        t.h = h; t.v = v; t.vld = vld; t.exp_pixel = e; t.name = n;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n       = 1'b0;
        h_cnt       = 10'd5;
        v_cnt       = 10'd5;
        valid       = 1'b1;
        frame_start = 1'b1;
        bricks      = '0;
        ball_x      = 10'd100;
        ball_y      = 10'd200;
        board_x     = 10'd600;

        // Reset, with frame_start held high that must be ignored.
        step(); step(); step();
        check("rst_pixel", pixel, 12'h000);
        check("rst_pixel_valid", 12'(pixel_valid), 12'h000);
        check("rst_frame_cnt", 12'(frame_cnt), 12'h000);
        rst_n       = 1'b1;
        frame_start = 1'b0;
        step();
        check("post_rst_frame_cnt", 12'(frame_cnt), 12'h000);

        set_cell(2, 1, 3'd4);
        for (int c = 1; c <= 7; c++) set_cell(c, 0, 3'(c));
        set_cell(3, 10, 3'd1);
        set_cell(19, 23, 3'd5);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("frame_cnt_one", 12'(frame_cnt), 12'h001);

        add(70, 25, 1'b1, 12'h0F0, "brick_c2r1");
        add(64, 25, 1'b1, 12'h000, "gap_x");
        add(70, 20, 1'b1, 12'h000, "gap_y");
        add(37, 5, 1'b1, 12'hF00, "pal1");
        add(69, 5, 1'b1, 12'hF80, "pal2");
        add(101, 5, 1'b1, 12'hFF0, "pal3");
        add(133, 5, 1'b1, 12'h0F0, "pal4");
        add(165, 5, 1'b1, 12'h0FF, "pal5");
        add(197, 5, 1'b1, 12'h00F, "pal6");
        add(229, 5, 1'b1, 12'hF0F, "pal7");
        add(5, 5, 1'b1, 12'h000, "empty_cell");
        add(100, 200, 1'b1, 12'hFFF, "ball_corner");
        add(101, 201, 1'b1, 12'hFFF, "ball_over_brick");
        add(116, 201, 1'b1, 12'hF00, "ball_right_edge");
        add(100, 209, 1'b1, 12'hFFF, "ball_bottom_row");
        add(100, 210, 1'b1, 12'hF00, "ball_below");
        add(639, 470, 1'b1, 12'h0AF, "board_right");
        add(600, 467, 1'b1, 12'h0AF, "board_corner");
        add(599, 470, 1'b1, 12'h000, "board_left_out");
        add(40, 470, 1'b1, 12'h000, "board_no_wrap");
        add(639, 477, 1'b1, 12'h0FF, "board_below");
        add(639, 479, 1'b1, 12'h0FF, "last_pixel");
        add(640, 479, 1'b1, 12'h000, "h_out");
        add(700, 500, 1'b1, 12'h000, "hv_out");
        add(70, 25, 1'b0, 12'h000, "not_valid");

        foreach (vecs[i]) begin
            run_px(vecs[i].h, vecs[i].v, vecs[i].vld);
            check({vecs[i].name, "_pixel"}, pixel, vecs[i].exp_pixel);
            check({vecs[i].name, "_pv"}, 12'(pixel_valid), 12'(vecs[i].vld));
        end

        // Map edits without frame_start stay invisible.
        set_cell(2, 1, 3'd0);
        run_px(70, 25, 1'b1);
        check("no_snap_unchanged", pixel, 12'h0F0);

        // Pixel in the frame_start cycle uses the old map; the next one uses the new map.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check("same_cycle_old_map", pixel, 12'h0F0);
        step();
        check("next_cycle_new_map", pixel, 12'h000);
        check("frame_cnt_two", 12'(frame_cnt), 12'h002);

        frame_start = 1'b1;
        for (int i = 0; i < 253; i++) step();
        frame_start = 1'b0;
        check("frame_cnt_255", 12'(frame_cnt), 12'h0FF);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("frame_cnt_wrap", 12'(frame_cnt), 12'h000);

        // Mid-line reset with a full pipeline.
        set_cell(2, 1, 3'd4);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        run_px(70, 25, 1'b1);
        check("pre_rst_pixel", pixel, 12'h0F0);
        rst_n = 1'b0;
        step();
        check("midrst_pv", 12'(pixel_valid), 12'h000);
        check("midrst_frame_cnt", 12'(frame_cnt), 12'h000);
        check("midrst_pixel", pixel, 12'h000);
        rst_n = 1'b1;
        h_cnt = 10'd5;
        v_cnt = 10'd5;
        step();
        check("release_pv_1", 12'(pixel_valid), 12'h000);
        step();
        check("release_pv_2", 12'(pixel_valid), 12'h001);
        check("cleared_ball_at_origin", pixel, 12'hFFF);
        run_px(70, 25, 1'b1);
        check("cleared_bricks", pixel, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
